// File: rtl/regfile_preloader.sv
// Register-file preloader.
// Sits on the processor's regfile write port. While idle it forwards processor writes untouched.
// On start it stalls the processor, optionally zero-clears r1..r(NUM_REGS-1), then writes a
// valid/ready stream of (register, value) pairs into the regfile, one entry per cycle.
module regfile_preloader #(
  parameter bit          CLEAR_ON_START = 1'b1,
  parameter int unsigned NUM_REGS       = 32
) (
  input  logic        clock,
  input  logic        reset,
  // Preload control
  input  logic        start,
  // Preload stream
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_data,
  input  logic        in_last,
  // Processor write port
  input  logic        cpu_we,
  input  logic [4:0]  cpu_rd,
  input  logic [31:0] cpu_data,
  // Regfile write port
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  // Status
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic [5:0]  load_count
);

  // Highest architectural register touched by the clear sweep.
  localparam logic [4:0] LastReg  = 5'(NUM_REGS - 1);
  localparam logic [5:0] CountMax = 6'd63;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StLoad,
    StDrain
  } state_e;

  state_e      state_q, state_d;

  // Clear sweep pointer: the register whose zero write is issued this cycle.
  logic [4:0]  clr_cnt_q, clr_cnt_d;

  // Registered regfile write; presented on rf_* one cycle after it is issued.
  logic        wr_we_q, wr_we_d;
  logic [4:0]  wr_rd_q, wr_rd_d;
  logic [31:0] wr_data_q, wr_data_d;

  // Stream entries written this preload (r0 entries excluded).
  logic [5:0]  cnt_q, cnt_d;

  logic        in_load;
  logic        handshake;
  logic        entry_counts;

  assign in_load      = (state_q == StLoad);
  assign handshake    = in_load & in_valid;
  // r0 is hardwired in the regfile; such entries are consumed but neither written nor counted.
  assign entry_counts = (in_reg != 5'd0);

  // State, sweep pointer, write register and entry counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      clr_cnt_q <= 5'd0;
      wr_we_q   <= 1'b0;
      wr_rd_q   <= 5'd0;
      wr_data_q <= 32'd0;
      cnt_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_we_q   <= wr_we_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic; a write is issued only from CLEAR or from a LOAD handshake.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_we_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d     = 6'd0;
          clr_cnt_d = 5'd1;
          state_d   = CLEAR_ON_START ? StClear : StLoad;
        end
      end

      StClear: begin
        wr_we_d   = 1'b1;
        wr_rd_d   = clr_cnt_q;
        wr_data_d = 32'd0;
        if (clr_cnt_q == LastReg) begin
          state_d = StLoad;
        end else begin
          clr_cnt_d = clr_cnt_q + 5'd1;
        end
      end

      StLoad: begin
        if (handshake) begin
          wr_we_d   = entry_counts;
          wr_rd_d   = in_reg;
          wr_data_d = in_data;
          if (entry_counts && (cnt_q != CountMax)) begin
            cnt_d = cnt_q + 6'd1;
          end
          if (in_last) begin
            state_d = StDrain;
          end
        end
      end

      // The final registered write is on rf_* now; nothing new is issued.
      StDrain: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status outputs and the regfile port mux: passthrough only while idle.
  always_comb begin
    busy       = (state_q != StIdle);
    cpu_hold   = busy;
    in_ready   = in_load;
    done       = (state_q == StDrain);
    load_count = cnt_q;
    if (busy) begin
      rf_we   = wr_we_q;
      rf_rd   = wr_rd_q;
      rf_data = wr_data_q;
    end else begin
      rf_we   = cpu_we;
      rf_rd   = cpu_rd;
      rf_data = cpu_data;
    end
  end

endmodule
